// File: rtl/uart_rx_fifo.sv
// UART receiver (4x oversampling, 2-of-3 majority per bit) feeding a small byte FIFO.
// Frames are 8N1, LSB first; bad stop bits pulse o_frame_err, pushes into a full FIFO set o_overflow.
module uart_rx_fifo #(
  parameter int unsigned UART_RX_CLK_DIV = 108,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int unsigned CW = (UART_RX_CLK_DIV > 1) ? $clog2(UART_RX_CLK_DIV) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(UART_RX_CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q;
  logic          tick;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    shift_q, shift_d;
  logic          maj;
  logic          push_c, ferr_c;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic          empty, full, pop, wr_en;

  // Line synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], i_rx};
  end
  assign rx_s = sync_q[1];

  // Free-running sample tick generator
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      cnt_q <= '0;
    else if (tick)  cnt_q <= '0;
    else            cnt_q <= cnt_q + CW'(1);
  end
  assign tick = (cnt_q == TICK_MAX);

  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      bit_q   <= 3'd0;
      samp_q  <= 2'b11;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
    end
  end

  // FSM next state: phases 1,2,3 sample; phase 3 resolves the bit
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    if (tick) begin
      if (state_q == IDLE) begin
        if (!rx_s) begin
          state_d = START;
          phase_d = 2'd1;
        end
      end else begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) samp_d[0] = rx_s;
        if (phase_q == 2'd2) samp_d[1] = rx_s;
        if (phase_q == 2'd3) begin
          case (state_q)
            START: begin
              state_d = maj ? IDLE : DATA;
              bit_d   = 3'd0;
            end
            DATA: begin
              shift_d = {maj, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = STOP;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // FSM outputs: stop-bit decision
  always_comb begin
    push_c = 1'b0;
    ferr_c = 1'b0;
    if (tick && state_q == STOP && phase_q == 2'd3) begin
      push_c = maj;
      ferr_c = !maj;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) o_frame_err <= 1'b0;
    else       o_frame_err <= ferr_c;
  end

  // FIFO: extra pointer MSB distinguishes full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop   = !empty && i_ready;
  assign wr_en = push_c && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q       <= '0;
      rd_q       <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      if (push_c && full && !pop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= shift_q;
  end

  assign o_valid = !empty;
  assign o_data  = mem[rd_q[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: tick-indexed frame decoder plus queue model, checked every cycle.
module tb_uart_rx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int BITC  = 4 * DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_overflow;

  int total = 0;
  int bad   = 0;
  bit abort = 1'b0;

  uart_rx_fifo #(.UART_RX_CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .i_rx(i_rx), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_n;
  bit         hist [0:65535];
  bit         tsamp [0:16383];
  bit         m_busy;
  int         m_start_k;
  int         m_stop_edge;
  logic [7:0] m_byte;
  logic [7:0] q [$];
  logic [7:0] m_pops [$];
  bit         m_ovf, m_ferr;
  int         m_ferr_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (i < m_pops.size()) ? 32'(m_pops[i]) : 32'hFFFF_FFFF;
  endfunction

  // Model: tick k sees the line as driven two edges earlier; a frame is 10 bits of 4 ticks from its start tick
  always @(posedge clk) begin : model
    int k, rel, bitno;
    bit s, maj, push;
    if (!rstn) begin
      m_n = 0; q.delete(); m_pops.delete();
      m_busy = 0; m_ovf = 0; m_ferr = 0; m_ferr_cnt = 0;
    end else begin
      m_n++;
      hist[m_n] = i_rx;
      m_ferr = 0;
      push = 0;
      if (m_n % DIV == 0) begin
        k = m_n / DIV;
        s = (m_n >= 3) ? hist[m_n-2] : 1'b1;
        tsamp[k] = s;
        if (!m_busy) begin
          if (!s) begin
            m_busy = 1; m_start_k = k; m_stop_edge = (k + 39) * DIV;
          end
        end else begin
          rel = k - m_start_k;
          if (rel % 4 == 3) begin
            maj = (int'(tsamp[k-2]) + int'(tsamp[k-1]) + int'(tsamp[k])) >= 2;
            bitno = rel / 4;
            if (bitno == 0) begin
              if (maj) m_busy = 0;
            end else if (bitno <= 8) begin
              m_byte[3'(bitno-1)] = maj;
            end else begin
              m_busy = 0;
              if (maj) push = 1;
              else begin m_ferr = 1; m_ferr_cnt++; end
            end
          end
        end
      end
      if (q.size() > 0 && i_ready) begin
        m_pops.push_back(q[0]);
        q.delete(0);
      end
      if (push) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back(m_byte);
      end
    end
  end

  // Per-cycle compare, 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ferr", 32'(o_frame_err), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
    end else begin
      check("valid", 32'(o_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("data", 32'(o_data), 32'(q[0]));
      check("frame_err", 32'(o_frame_err), 32'(m_ferr));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BITC; c++) begin
        @(negedge clk);
        if (abort) begin i_rx = 1'b1; return; end
        i_rx = fr[b];
      end
    end
    @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; i_ready = 1'b0; i_rx = 1'b1; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("lit_rst_valid", 32'(o_valid), 32'd0);
    check("lit_rst_ferr", 32'(o_frame_err), 32'd0);
    check("lit_rst_ovf", 32'(o_overflow), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit pulsed;
    bit rdone;

    // Single good frame
    do_reset();
    i_ready = 1'b1;
    idle(7);
    send(8'h55, 1'b1);
    idle(40);
    check("p55_cnt", 32'(m_pops.size()), 32'd1);
    check("p55_val", pop_at(0), 32'h55);
    check("p55_ferr", 32'(m_ferr_cnt), 32'd0);

    // Bad stop bit, then a clean frame
    do_reset();
    i_ready = 1'b1;
    idle(5);
    send(8'hA3, 1'b0);
    idle(30);
    check("ferr_cnt", 32'(m_ferr_cnt), 32'd1);
    check("ferr_nopop", 32'(m_pops.size()), 32'd0);
    send(8'h3C, 1'b1);
    idle(40);
    check("p3c_val", pop_at(0), 32'h3C);
    check("p3c_cnt", 32'(m_pops.size()), 32'd1);

    // 4-clock low glitch, then a frame to prove the receiver went back to idle
    do_reset();
    i_ready = 1'b1;
    idle(9);
    @(negedge clk); i_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_rx = 1'b1;
    idle(60);
    check("glitch_nopop", 32'(m_pops.size()), 32'd0);
    check("glitch_noferr", 32'(m_ferr_cnt), 32'd0);
    send(8'h5A, 1'b1);
    idle(40);
    check("glitch_next", pop_at(0), 32'h5A);

    // Overflow on the fifth byte
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      idle(6);
    end
    idle(40);
    check("lit_ovf", 32'(o_overflow), 32'd1);
    check("m_ovf", 32'(m_ovf), 32'd1);
    @(negedge clk); i_ready = 1'b1;
    idle(10);
    i_ready = 1'b0;
    check("ovf_cnt", 32'(m_pops.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("ovf_order", pop_at(i), 32'(i + 1));
    check("ovf_empty", 32'(o_valid), 32'd0);

    // Full FIFO with a pop in the same cycle as the push
    do_reset();
    send(8'h11, 1'b1); idle(6);
    send(8'h22, 1'b1); idle(6);
    send(8'h33, 1'b1); idle(6);
    send(8'h44, 1'b1); idle(6);
    pulsed = 1'b0;
    fork
      send(8'h77, 1'b1);
      for (int c = 0; c < 260; c++) begin
        @(negedge clk);
        i_ready = m_busy && (m_n + 1 == m_stop_edge);
        if (i_ready) pulsed = 1'b1;
      end
    join
    i_ready = 1'b0;
    idle(5);
    check("pulse_seen", 32'(pulsed), 32'd1);
    check("full_noovf", 32'(o_overflow), 32'd0);
    @(negedge clk); i_ready = 1'b1;
    idle(10);
    check("full_cnt", 32'(m_pops.size()), 32'd5);
    check("full_0", pop_at(0), 32'h11);
    check("full_1", pop_at(1), 32'h22);
    check("full_2", pop_at(2), 32'h33);
    check("full_3", pop_at(3), 32'h44);
    check("full_4", pop_at(4), 32'h77);

    // Reset during data bit 4 of 0xF0
    do_reset();
    i_ready = 1'b1;
    idle(3);
    fork
      send(8'hF0, 1'b1);
      begin
        repeat (4 + BITC * 5 + 8) @(negedge clk);
        rstn = 1'b0; abort = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
      end
    join
    abort = 1'b0;
    i_ready = 1'b1;
    idle(20);
    send(8'h12, 1'b1);
    idle(40);
    check("rstmid_cnt", 32'(m_pops.size()), 32'd1);
    check("rstmid_val", pop_at(0), 32'h12);
    check("rstmid_ferr", 32'(m_ferr_cnt), 32'd0);
    check("rstmid_ovf", 32'(o_overflow), 32'd0);
    check("rstmid_ferr_pin", 32'(o_frame_err), 32'd0);

    // Random frames, glitches, gaps and back-pressure
    do_reset();
    rdone = 1'b0;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          if ($urandom_range(4) == 0) begin
            @(negedge clk); i_rx = 1'b0;
            repeat ($urandom_range(8, 1)) @(negedge clk);
            i_rx = 1'b1;
            idle($urandom_range(60, 20));
          end
          send(8'($urandom), $urandom_range(7) != 0);
          idle($urandom_range(30, 4));
        end
        idle(40);
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(negedge clk);
        i_ready = ($urandom_range(99) < 30);
      end
    join
    @(negedge clk); i_ready = 1'b1;
    idle(20);
    check("rand_drain", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter UART_RX_CLK_DIV, default 108, meaning clk cycles per sample tick (4 ticks per bit; 50 MHz/4/115200).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive byte buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port i_rx  input  1  asynchronous UART serial line, idle high.
REQ-006 The block SHALL have port o_valid  output  1  FIFO head byte available.
REQ-007 The block SHALL have port o_data  output  8  FIFO head byte, meaningful only while o_valid.
REQ-008 The block SHALL have port i_ready  input  1  consumer accepts head byte when o_valid&i_ready.
REQ-009 The block SHALL have port o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 The block SHALL have port o_overflow  output  1  sticky flag: byte dropped on full FIFO.

Function
REQ-011 i_rx SHALL pass a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value.
REQ-012 A tick counter SHALL count 0..UART_RX_CLK_DIV-1 and wrap, free-running; a tick is the cycle the counter equals UART_RX_CLK_DIV-1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and a 2-bit phase counter; all FSM actions occur only on ticks.
REQ-014 IDLE: a tick with synchronized line 0 SHALL enter START with phase=1 (that tick counts as phase 0).
REQ-015 In START/DATA/STOP, samples at phases 1,2,3 SHALL be collected; at phase 3 the bit value is their 2-of-3 majority, and phase wraps to 0.
REQ-016 START majority 1 (glitch) SHALL return to IDLE with no output; majority 0 SHALL enter DATA with bit index 0.
REQ-017 DATA SHALL shift 8 bits LSB first; after bit 7 SHALL enter STOP.
REQ-018 STOP majority 1 SHALL issue a push of the assembled byte and return to IDLE; majority 0 SHALL discard the byte, pulse o_frame_err for exactly one cycle, and return to IDLE.
REQ-019 The FIFO SHALL be FIFO_DEPTH entries with log2(FIFO_DEPTH)+1-bit read/write pointers; empty when pointers equal, full when only MSBs differ.
REQ-020 o_valid SHALL equal not-empty; o_data SHALL be the entry at the read pointer (combinational from storage).
REQ-021 Pop SHALL occur on o_valid&i_ready; pop with o_valid=0 SHALL have no effect.
REQ-022 Push latency: byte SHALL appear on o_data with o_valid=1 the cycle after the stop-bit tick when FIFO was empty.
REQ-023 Push when full and no pop same cycle SHALL drop the byte, leave FIFO unchanged, and set o_overflow=1 until reset.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when full (push accepted, no overflow) and when count=1 (o_valid stays 1, o_data advances).
REQ-025 Pointer increments SHALL wrap modulo 2*FIFO_DEPTH; data order SHALL be strict FIFO across wrap.

Reset
REQ-026 rstn=0 SHALL asynchronously force: FSM IDLE, phase 0, tick counter 0, synchronizer 1, pointers 0, o_valid 0, o_frame_err 0, o_overflow 0; o_data SHALL be don't-care (storage not reset).
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release, reception resumes only on a new start bit detected in IDLE.

Verification (UART_RX_CLK_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-028 Send 0x55 (16 clk/bit), i_ready=1 -> o_valid one cycle with o_data=0x55; no o_frame_err.
REQ-029 Send 0xA3 with stop bit held 0 -> one-cycle o_frame_err, o_valid stays 0, next frame 0x3C received correctly.
REQ-030 Low glitch of 4 clk on idle line -> no o_valid, no o_frame_err, FSM back to IDLE.
REQ-031 i_ready=0, send 0x01..0x05 -> o_overflow=1 after fifth; then popping returns 0x01,0x02,0x03,0x04, o_valid drops.
REQ-032 FIFO full, i_ready pulsed in the stop-bit tick cycle of 0x77 -> no overflow, pops return remaining bytes then 0x77.
REQ-033 rstn asserted during bit 4 of 0xF0, released, then send 0x12 -> only 0x12 delivered, all flags 0.
